// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-memory access per instruction over req/gnt/rvalid,
// store lane formation, load alignment/extension and upstream stall while an access is in flight.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        fault_out
);
    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RSP, DONE} state_e;

    state_e            state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [1:0]  lane;
    logic        f3_illegal, misaligned, bad, mem_op, access, bad_access;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        req_c, stall_c, fault_c;
    logic [31:0] mem_data_c;

    // Access legality: size/alignment and conflicting read+write
    assign lane       = alu_result_in[1:0];
    assign f3_illegal = (funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11);
    assign misaligned = ((funct3_in[1:0] == 2'b01) && lane[0]) ||
                        ((funct3_in[1:0] == 2'b10) && (lane != 2'b00));
    assign bad        = f3_illegal || misaligned || (MemRead_in && MemWrite_in);
    assign mem_op     = valid_in && (MemRead_in || MemWrite_in);
    assign access     = mem_op && !bad;
    assign bad_access = mem_op && bad;

    // Store byte enables and lane-replicated write data
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (lane)
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            2'd3:    ld_byte = dmem_rdata[31:24];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_in)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            fault_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        tmo_d      = tmo_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        fault_c    = 1'b0;
        mem_data_c = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    req_c = 1'b1;
                    if (dmem_gnt) begin
                        tmo_d = '0;
                        if (MemRead_in) begin
                            stall_c = 1'b1;
                            state_d = WAIT_RSP;
                        end
                    end else begin
                        stall_c = 1'b1;
                        if (tmo_q == TMO_LAST) begin
                            state_d = DONE;
                            fault_d = 1'b1;
                            rdata_d = '0;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                end else begin
                    tmo_d   = '0;
                    fault_c = bad_access;
                end
            end
            WAIT_RSP: begin
                stall_c = 1'b1;
                if (dmem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = DONE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = DONE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                mem_data_c = rdata_q;
                fault_c    = fault_q;
                state_d    = IDLE;
                tmo_d      = '0;
                fault_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and writeback outputs are forced quiet while reset is held
    assign dmem_req       = rst_n && req_c;
    assign mem_stall      = rst_n && stall_c;
    assign fault_out      = rst_n && fault_c;
    assign mem_data_out   = rst_n ? mem_data_c : 32'd0;
    assign RegWrite_out   = rst_n && RegWrite_in && valid_in && !stall_c && !fault_c;
    assign dmem_we        = MemWrite_in;
    assign dmem_addr      = {alu_result_in[31:2], 2'b00};
    assign alu_result_out = alu_result_in;
    assign rd_out         = rd_in;
    assign MemToReg_out   = MemToReg_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed instructions push expected retire and bus
// records; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_stage_lsu;
    logic        clk, rst_n;
    logic        valid_in, MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] mem_data_out, alu_result_out;
    logic [4:0]  rd_out;
    logic        RegWrite_out, MemToReg_out, fault_out;

    typedef struct packed {
        logic [31:0] data;
        logic        rw;
        logic        flt;
        logic [7:0]  stalls;
        logic [7:0]  reqs;
        logic [4:0]  rd;
        logic [31:0] alu;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic        lanes;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cfg_gnt  = 0;
    int          cfg_rv   = 0;
    logic [31:0] cfg_data = 32'd0;
    int          stall_cnt = 0;
    int          req_cnt   = 0;

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .fault_out(fault_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"},   32'(dmem_req),     32'd0);
        chk({tag, "_stall"}, 32'(mem_stall),    32'd0);
        chk({tag, "_rw"},    32'(RegWrite_out), 32'd0);
        chk({tag, "_fault"}, 32'(fault_out),    32'd0);
        chk({tag, "_data"},  mem_data_out,      32'd0);
    endtask

    function automatic exp_t ex(input logic [31:0] data, input logic rw, input logic flt,
                                input int st, input int rq, input logic [4:0] rd,
                                input logic [31:0] alu);
        exp_t e;
        e.data = data; e.rw = rw; e.flt = flt; e.stalls = 8'(st); e.reqs = 8'(rq);
        e.rd = rd; e.alu = alu;
        return e;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [31:0] addr, input logic lanes,
                                    input logic [3:0] be, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.lanes = lanes; r.be = be; r.wdata = wdata;
        return r;
    endfunction

    // Memory responder: grant after cfg_gnt request cycles, rvalid cfg_rv cycles after the
    // cycle following a read grant
    initial begin : responder
        int          g_cnt;
        int          rv_cnt;
        bit          in_acc;
        bit          pend_rv;
        logic [31:0] pend_data;
        g_cnt = 0; rv_cnt = 0; in_acc = 0; pend_rv = 0; pend_data = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            if (pend_rv) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = pend_data;
                    pend_rv     = 0;
                end else begin
                    rv_cnt--;
                end
            end
            if (!dmem_req) begin
                in_acc = 0;
            end else begin
                if (!in_acc) begin
                    in_acc = 1;
                    g_cnt  = cfg_gnt;
                end
                if (g_cnt == 0) begin
                    dmem_gnt = 1'b1;
                    in_acc   = 0;
                    if (!dmem_we) begin
                        pend_rv   = 1;
                        rv_cnt    = cfg_rv;
                        pend_data = cfg_data;
                    end
                end else begin
                    g_cnt--;
                end
            end
        end
    end

    // Monitor: bus grants and instruction retirement checked against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        req_t r;
        if (!rst_n) begin
            stall_cnt = 0;
            req_cnt   = 0;
        end else begin
            if (dmem_req && dmem_gnt) begin
                if (req_q.size() == 0) begin
                    fail_evt("unexpected_dmem_grant");
                end else begin
                    r = req_q.pop_front();
                    chk("dmem_we",   32'(dmem_we), 32'(r.we));
                    chk("dmem_addr", dmem_addr,    r.addr);
                    if (r.lanes) begin
                        chk("dmem_be",    32'(dmem_be), 32'(r.be));
                        chk("dmem_wdata", dmem_wdata,   r.wdata);
                    end
                end
            end
            if (valid_in) begin
                if (dmem_req) req_cnt++;
                if (mem_stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        fail_evt("unexpected_retire");
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_data_out",   mem_data_out,        e.data);
                        chk("RegWrite_out",   32'(RegWrite_out),   32'(e.rw));
                        chk("fault_out",      32'(fault_out),      32'(e.flt));
                        chk("stall_cycles",   32'(stall_cnt),      32'(e.stalls));
                        chk("req_cycles",     32'(req_cnt),        32'(e.reqs));
                        chk("rd_out",         32'(rd_out),         32'(e.rd));
                        chk("alu_result_out", alu_result_out,      e.alu);
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
            end
        end
    end

    task automatic issue(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                         input int gd, input int rvd, input logic [31:0] rsp, input exp_t e);
        bit done;
        done     = 0;
        cfg_gnt  = gd;
        cfg_rv   = rvd;
        cfg_data = rsp;
        exp_q.push_back(e);
        valid_in = 1'b1; MemRead_in = mr; MemWrite_in = mw; RegWrite_in = rw;
        MemToReg_in = mr; funct3_in = f3; alu_result_in = addr; store_data_in = sd; rd_in = rd;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!mem_stall) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_evt("retire_timeout");
        @(posedge clk);
        #1;
        valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1;
        MemToReg_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h100;
        store_data_in = 32'd0; rd_in = 5'd1;
        repeat (2) begin
            @(negedge clk);
            chk_quiet("reset");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0; MemRead_in = 1'b0; RegWrite_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("idle");
        @(posedge clk);
        #1;

        // Loads with immediate grant and response
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b010, 32'h100, 0, 5'd5, 0, 0, 32'hDEADBEEF,
              ex(32'hDEADBEEF, 1, 0, 2, 1, 5'd5, 32'h100));
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b000, 32'h103, 0, 5'd6, 0, 0, 32'h80FF1234,
              ex(32'hFFFFFF80, 1, 0, 2, 1, 5'd6, 32'h103));
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b100, 32'h103, 0, 5'd7, 0, 0, 32'h80FF1234,
              ex(32'h00000080, 1, 0, 2, 1, 5'd7, 32'h103));
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b001, 32'h102, 0, 5'd8, 0, 0, 32'h80FF1234,
              ex(32'hFFFF80FF, 1, 0, 2, 1, 5'd8, 32'h102));
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b101, 32'h100, 0, 5'd9, 0, 0, 32'h80FF1234,
              ex(32'h00001234, 1, 0, 2, 1, 5'd9, 32'h100));
        req_q.push_back(mk_req(1'b0, 32'h100, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b000, 32'h101, 0, 5'd10, 0, 0, 32'h80FF1234,
              ex(32'h00000012, 1, 0, 2, 1, 5'd10, 32'h101));

        // Stores: delayed grant, halfword, word
        req_q.push_back(mk_req(1'b1, 32'h100, 1'b1, 4'b0010, 32'hABABABAB));
        issue(0, 1, 0, 3'b000, 32'h101, 32'h123456AB, 5'd0, 3, 0, 32'h0,
              ex(32'h0, 0, 0, 3, 4, 5'd0, 32'h101));
        req_q.push_back(mk_req(1'b1, 32'h100, 1'b1, 4'b1100, 32'hBEEFBEEF));
        issue(0, 1, 0, 3'b001, 32'h102, 32'hCAFEBEEF, 5'd0, 0, 0, 32'h0,
              ex(32'h0, 0, 0, 0, 1, 5'd0, 32'h102));
        req_q.push_back(mk_req(1'b1, 32'h104, 1'b1, 4'b1111, 32'h11223344));
        issue(0, 1, 0, 3'b010, 32'h104, 32'h11223344, 5'd0, 0, 0, 32'h0,
              ex(32'h0, 0, 0, 0, 1, 5'd0, 32'h104));

        // Bad accesses: same-cycle fault, no request, no stall
        issue(1, 0, 1, 3'b001, 32'h101, 0, 5'd3, 0, 0, 32'h0, ex(32'h0, 0, 1, 0, 0, 5'd3, 32'h101));
        issue(1, 0, 1, 3'b011, 32'h100, 0, 5'd3, 0, 0, 32'h0, ex(32'h0, 0, 1, 0, 0, 5'd3, 32'h100));
        issue(1, 1, 1, 3'b010, 32'h100, 0, 5'd4, 0, 0, 32'h0, ex(32'h0, 0, 1, 0, 0, 5'd4, 32'h100));
        issue(0, 1, 0, 3'b010, 32'h102, 0, 5'd0, 0, 0, 32'h0, ex(32'h0, 0, 1, 0, 0, 5'd0, 32'h102));

        // Non-memory instruction ignores funct3 legality
        issue(0, 0, 1, 3'b011, 32'h55, 0, 5'd11, 0, 0, 32'h0, ex(32'h0, 1, 0, 0, 0, 5'd11, 32'h55));

        // Load with grant and response wait states
        req_q.push_back(mk_req(1'b0, 32'h200, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b010, 32'h200, 0, 5'd12, 2, 1, 32'h0BADF00D,
              ex(32'h0BADF00D, 1, 0, 5, 3, 5'd12, 32'h200));

        // Grant timeout, then a normal load right after
        issue(1, 0, 1, 3'b010, 32'h300, 0, 5'd13, 1000, 0, 32'h0,
              ex(32'h0, 0, 1, 16, 16, 5'd13, 32'h300));
        req_q.push_back(mk_req(1'b0, 32'h104, 1'b0, 4'h0, 32'h0));
        issue(1, 0, 1, 3'b010, 32'h104, 0, 5'd14, 0, 0, 32'h13579BDF,
              ex(32'h13579BDF, 1, 0, 2, 1, 5'd14, 32'h104));

        // Empty slot carrying MemRead must not touch memory
        MemRead_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h100;
        @(negedge clk);
        chk("bubble_req",   32'(dmem_req),  32'd0);
        chk("bubble_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        MemRead_in = 1'b0;

        // Reset while waiting for a response; the late rvalid must be ignored
        cfg_gnt = 0; cfg_rv = 3; cfg_data = 32'h77777777;
        req_q.push_back(mk_req(1'b0, 32'h300, 1'b0, 4'h0, 32'h0));
        valid_in = 1'b1; MemRead_in = 1'b1; RegWrite_in = 1'b1; MemToReg_in = 1'b1;
        funct3_in = 3'b010; alu_result_in = 32'h300; rd_in = 5'd15;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        chk_quiet("midreset");
        @(posedge clk);
        #3;
        valid_in = 1'b0; MemRead_in = 1'b0; RegWrite_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 0, 1, 3'b000, 32'h1234, 0, 5'd9, 0, 0, 32'h0, ex(32'h0, 1, 0, 0, 0, 5'd9, 32'h1234));
        issue(0, 0, 1, 3'b000, 32'h4321, 0, 5'd2, 0, 0, 32'h0, ex(32'h0, 1, 0, 0, 0, 5'd2, 32'h4321));
        req_q.push_back(mk_req(1'b1, 32'h108, 1'b1, 4'b1111, 32'hA5A5_5A5A));
        issue(0, 1, 0, 3'b010, 32'h108, 32'hA5A5_5A5A, 5'd0, 0, 0, 32'h0,
              ex(32'h0, 0, 0, 0, 1, 5'd0, 32'h108));

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
